vga_sync_monitor: RTL and testbench



---
 rtl/vga_mon_pkg.sv | 22 ++
 rtl/vga_sync_monitor_edge_fall.sv | 24 ++
 rtl/vga_sync_monitor.sv | 196 +++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mon_pkg.sv
// Shared types and widths for the VGA sync monitor.
package vga_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        CHECK1 = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam int HCNT_W  = 12;
    localparam int LCNT_W  = 11;
    localparam int PIXX_W  = 11;
    localparam int PIXY_W  = 10;
    localparam int SUM_W   = 24;
    localparam int FCNT_W  = 16;

    function automatic int span4(input int a, input int b, input int c, input int d);
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/vga_sync_monitor_edge_fall.sv
// Registers one sync input and flags the sample where it first reads low.
module edge_fall (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q,
    output logic q_prev,
    output logic fall
);

    // Syncs idle high, so resetting high avoids a false edge after reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            q      <= 1'b1;
            q_prev <= 1'b1;
        end else begin
            q      <= d;
            q_prev <= q;
        end
    end

    assign fall = q_prev & ~q;

endmodule

// File: rtl/vga_sync_monitor.sv
// Receiver-side checker for VGA timing: geometry checks, sticky errors, lock FSM,
// per-frame RGB checksum and active-pixel coordinates.
module vga_sync_monitor
    import vga_mon_pkg::*;
#(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                vga_hs,
    input  logic                vga_vs,
    input  logic                vga_blank,
    input  logic [7:0]          vga_r,
    input  logic [7:0]          vga_g,
    input  logic [7:0]          vga_b,
    input  logic                clr_err,
    output logic                locked,
    output logic                h_err,
    output logic                v_err,
    output logic                blank_err,
    output logic [FCNT_W-1:0]   frame_cnt,
    output logic [SUM_W-1:0]    frame_sum,
    output logic [PIXX_W-1:0]   pix_x,
    output logic [PIXY_W-1:0]   pix_y,
    output logic                pix_valid,
    output state_t              dbg_state
);

    localparam int HTOTAL = span4(HDISP, HFP, HPULSE, HBP);
    localparam int VTOTAL = span4(VDISP, VFP, VPULSE, VBP);

    localparam logic [HCNT_W-1:0] H_LAST  = HCNT_W'(HTOTAL - 1);
    localparam logic [HCNT_W-1:0] H_PULSE = HCNT_W'(HPULSE);
    localparam logic [HCNT_W-1:0] HW_LO   = HCNT_W'(HPULSE + HBP);
    localparam logic [HCNT_W-1:0] HW_HI   = HCNT_W'(HPULSE + HBP + HDISP - 1);
    localparam logic [HCNT_W-1:0] H_MAX   = '1;
    localparam logic [LCNT_W-1:0] L_LAST  = LCNT_W'(VTOTAL - 1);
    localparam logic [LCNT_W-1:0] V_PULSE = LCNT_W'(VPULSE);
    localparam logic [LCNT_W-1:0] LA_LO   = LCNT_W'(VPULSE + VBP);
    localparam logic [LCNT_W-1:0] LA_HI   = LCNT_W'(VPULSE + VBP + VDISP - 1);
    localparam logic [LCNT_W-1:0] L_MAX   = '1;

    logic hs_q, hs_p, hs_fall, hs_rise;
    logic vs_q, vs_p, vs_fall, vs_rise;
    logic blank_q;
    logic [7:0] r_q, g_q, b_q;

    edge_fall u_hs_edge (.clk(clk), .nrst(nrst), .d(vga_hs), .q(hs_q), .q_prev(hs_p), .fall(hs_fall));
    edge_fall u_vs_edge (.clk(clk), .nrst(nrst), .d(vga_vs), .q(vs_q), .q_prev(vs_p), .fall(vs_fall));

    assign hs_rise = hs_q & ~hs_p;
    assign vs_rise = vs_q & ~vs_p;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            blank_q <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            blank_q <= vga_blank;
            r_q     <= vga_r;
            g_q     <= vga_g;
            b_q     <= vga_b;
        end
    end

    // *_cur are the counter values that belong to the current registered sample.
    logic [HCNT_W-1:0] hcnt, hcnt_cur;
    logic [LCNT_W-1:0] lcnt, lcnt_cur;

    always_comb begin
        hcnt_cur = hcnt;
        if (hs_fall)
            hcnt_cur = '0;
        else if (hcnt != H_MAX)
            hcnt_cur = hcnt + 1'b1;
    end

    always_comb begin
        lcnt_cur = lcnt;
        if (vs_fall)
            lcnt_cur = '0;
        else if (hs_fall && lcnt != L_MAX)
            lcnt_cur = lcnt + 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hcnt <= '0;
            lcnt <= '0;
        end else begin
            hcnt <= hcnt_cur;
            lcnt <= lcnt_cur;
        end
    end

    state_t state, state_nxt;
    logic   checking;
    logic   line_act_old, line_act_cur, blank_exp;
    logic   h_set, v_set, b_set, err_now;

    assign checking     = (state != IDLE);
    assign line_act_old = (lcnt >= LA_LO) && (lcnt <= LA_HI);
    assign line_act_cur = (lcnt_cur >= LA_LO) && (lcnt_cur <= LA_HI);
    assign blank_exp    = line_act_cur && (hcnt_cur >= HW_LO) && (hcnt_cur <= HW_HI);

    assign h_set = checking && ((hs_fall && line_act_old && hcnt != H_LAST) ||
                                (hs_rise && line_act_cur && hcnt_cur != H_PULSE) ||
                                (!hs_fall && hcnt_cur == H_MAX));
    assign v_set = checking && ((vs_fall && lcnt != L_LAST) ||
                                (vs_rise && lcnt_cur != V_PULSE) ||
                                (!vs_fall && lcnt_cur == L_MAX));
    assign b_set = checking && (blank_q != blank_exp);
    assign err_now = h_set | v_set | b_set;

    // frame_bad remembers any error since the last VS fall so SYNC only
    // advances on a frame that was clean end to end.
    logic frame_bad;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vs_fall) state_nxt = SYNC;
            SYNC:    if (vs_fall && !frame_bad && !err_now) state_nxt = CHECK1;
            CHECK1:  if (err_now) state_nxt = SYNC;
                     else if (vs_fall) state_nxt = LOCKED;
            LOCKED:  if (err_now) state_nxt = SYNC;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            frame_bad <= 1'b0;
            h_err     <= 1'b0;
            v_err     <= 1'b0;
            blank_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_bad <= vs_fall ? 1'b0 : (frame_bad | err_now);
            h_err     <= h_set | (h_err & ~clr_err);
            v_err     <= v_set | (v_err & ~clr_err);
            blank_err <= b_set | (blank_err & ~clr_err);
        end
    end

    assign locked    = (state == LOCKED);
    assign dbg_state = state;

    logic [SUM_W-1:0] acc, pix_sum;
    assign pix_sum = {16'b0, r_q} + {16'b0, g_q} + {16'b0, b_q};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc       <= '0;
            frame_sum <= '0;
            frame_cnt <= '0;
        end else begin
            acc <= (vs_fall ? '0 : acc) + (blank_q ? pix_sum : '0);
            if (vs_fall && checking) begin
                frame_sum <= acc;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // pix_valid doubles as the previous blank sample for run-start detection.
    logic seen_act, seen_cur;
    assign seen_cur = vs_fall ? 1'b0 : seen_act;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            seen_act  <= 1'b0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
        end else begin
            seen_act  <= seen_cur | blank_q;
            pix_valid <= blank_q;
            if (blank_q)
                pix_x <= pix_valid ? pix_x + 1'b1 : '0;
            if (blank_q && !pix_valid)
                pix_y <= seen_cur ? pix_y + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor with a timestamp-based reference model.
module tb_vga_sync_monitor;
    import vga_mon_pkg::*;

    localparam int HD = 16, HF = 4, HP = 8, HB = 4;
    localparam int VD = 10, VF = 2, VP = 2, VB = 3;
    localparam int HT = HD + HF + HP + HB;
    localparam int VT = VD + VF + VP + VB;
    localparam int HW_LO = HP + HB, HW_HI = HP + HB + HD - 1;
    localparam int LA_LO = VP + VB, LA_HI = VP + VB + VD - 1;
    localparam int W = 66;

    logic clk = 1'b0;
    logic nrst, hs, vs, blank, clr_err;
    logic [7:0] r, g, b;
    logic locked, h_err, v_err, blank_err, pix_valid;
    logic [15:0] frame_cnt;
    logic [23:0] frame_sum;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    state_t dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_sync_monitor #(.HDISP(HD), .VDISP(VD), .HFP(HF), .HPULSE(HP), .HBP(HB),
                       .VFP(VF), .VPULSE(VP), .VBP(VB)) dut (
        .clk(clk), .nrst(nrst), .vga_hs(hs), .vga_vs(vs), .vga_blank(blank),
        .vga_r(r), .vga_g(g), .vga_b(b), .clr_err(clr_err),
        .locked(locked), .h_err(h_err), .v_err(v_err), .blank_err(blank_err),
        .frame_cnt(frame_cnt), .frame_sum(frame_sum), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .dbg_state(dbg_state)
    );

    // Reference model: positions from timestamps of the last sync falls.
    int m_t, m_thf, m_lines, m_stage, m_fcnt, m_fsum, m_acc, m_x, m_y, m_runs;
    bit m_bad, m_hs_last, m_vs_last, m_pv, m_h, m_v, m_b;
    logic p_hs, p_vs, p_blank;
    logic [7:0] p_r, p_g, p_b;
    logic [W-1:0] exp_q[$];

    function automatic bit active_line(input int l);
        return (l >= LA_LO) && (l <= LA_HI);
    endfunction

    task automatic model_reset();
        m_t = 0; m_thf = -1; m_lines = 0; m_stage = 0; m_fcnt = 0; m_fsum = 0;
        m_acc = 0; m_x = 0; m_y = 0; m_runs = 0;
        m_bad = 0; m_hs_last = 1; m_vs_last = 1; m_pv = 0; m_h = 0; m_v = 0; m_b = 0;
        p_hs = 1; p_vs = 1; p_blank = 0; p_r = 0; p_g = 0; p_b = 0;
    endtask

    task automatic model_step(input logic s_hs, input logic s_vs, input logic s_blank,
                              input logic [7:0] s_r, input logic [7:0] s_g,
                              input logic [7:0] s_b, input logic clr);
        bit hf, hr, vf, vr, chk, hset, vset, bset, err, bexp;
        int pos, len, l_new;
        hf = m_hs_last && !s_hs;
        hr = !m_hs_last && s_hs;
        vf = m_vs_last && !s_vs;
        vr = !m_vs_last && s_vs;
        len = m_t - m_thf;
        pos = hf ? 0 : len;
        l_new = vf ? 0 : m_lines + (hf ? 1 : 0);
        chk = (m_stage != 0);
        hset = chk && ((hf && active_line(m_lines) && len != HT) ||
                       (hr && active_line(l_new) && pos != HP) || (!hf && pos >= 4095));
        vset = chk && ((vf && m_lines != VT - 1) || (vr && l_new != VP) ||
                       (!vf && l_new >= 2047));
        bexp = active_line(l_new) && pos >= HW_LO && pos <= HW_HI;
        bset = chk && (s_blank != bexp);
        err = hset || vset || bset;
        case (m_stage)
            0: if (vf) m_stage = 1;
            1: if (vf && !m_bad && !err) m_stage = 2;
            2: if (err) m_stage = 1; else if (vf) m_stage = 3;
            default: if (err) m_stage = 1;
        endcase
        m_bad = vf ? 1'b0 : (m_bad || err);
        m_h = hset || (m_h && !clr);
        m_v = vset || (m_v && !clr);
        m_b = bset || (m_b && !clr);
        if (vf && chk) begin
            m_fsum = m_acc;
            m_fcnt = (m_fcnt + 1) % 65536;
        end
        m_acc = ((vf ? 0 : m_acc) + (s_blank ? int'(s_r) + int'(s_g) + int'(s_b) : 0)) % (1 << 24);
        if (vf) m_runs = 0;
        if (s_blank) begin
            if (!m_pv) begin
                m_runs++;
                m_x = 0;
                m_y = (m_runs - 1) % 1024;
            end else begin
                m_x = (m_x + 1) % 2048;
            end
        end
        m_pv = s_blank;
        if (hf) m_thf = m_t;
        m_lines = l_new;
        m_t++;
        m_hs_last = s_hs;
        m_vs_last = s_vs;
    endtask

    always @(negedge clk) begin : cmp
        logic [W-1:0] e, gv;
        gv = {locked, h_err, v_err, blank_err, frame_cnt, frame_sum, pix_valid, pix_x, pix_y};
        if (!nrst) begin
            model_reset();
            exp_q.delete();
            checks++;
            if (gv != '0 || dbg_state != IDLE) begin
                errors++;
                $display("FAIL reset_outputs t=%0t got %h expected 0", $time, gv);
            end
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!e[21]) begin
                    e[20:0] = '0;
                    gv[20:0] = '0;
                end
                checks++;
                if (gv != e) begin
                    errors++;
                    $display("FAIL model_cmp t=%0t got %h expected %h", $time, gv, e);
                end
            end
            model_step(p_hs, p_vs, p_blank, p_r, p_g, p_b, clr_err);
            exp_q.push_back({m_stage == 3, m_h, m_v, m_b, 16'(m_fcnt), 24'(m_fsum), m_pv,
                             11'(m_x), 10'(m_y)});
            p_hs = hs; p_vs = vs; p_blank = blank; p_r = r; p_g = g; p_b = b;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic drive(input logic h_s, input logic v_s, input logic bl,
                         input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        @(posedge clk);
        #1;
        hs = h_s; vs = v_s; blank = bl; r = rr; g = gg; b = bb;
    endtask

    task automatic send_frame(input int n_lines, input int long_line, input int vs_lines,
                              input int early_line, input int pat);
        for (int v = 0; v < n_lines; v++) begin
            int len;
            len = (v == long_line) ? HT + 1 : HT;
            for (int h = 0; h < len; h++) begin
                logic act;
                act = (v >= LA_LO && v <= LA_HI) &&
                      ((h >= HW_LO && h <= HW_HI) || (v == early_line && h == HW_LO - 1));
                if (pat == 0)
                    drive(h >= HP, v >= vs_lines, act, 8'd1, 8'd2, 8'd3);
                else
                    drive(h >= HP, v >= vs_lines, act, 8'(h * 7 + v), 8'(v * 13), 8'(h ^ v));
            end
        end
    endtask

    task automatic nominal(input int n);
        for (int i = 0; i < n; i++) send_frame(VT, -1, VP, -1, 0);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1; clr_err = 1'b1;
        @(posedge clk); #1; clr_err = 1'b0;
        settle();
    endtask

    initial begin
        nrst = 1'b0; hs = 1'b1; vs = 1'b1; blank = 1'b0; clr_err = 1'b0;
        r = '0; g = '0; b = '0;
        repeat (4) @(posedge clk);
        #1 nrst = 1'b1;
        repeat (5) @(posedge clk);
        settle();
        check("idle_locked", 32'(locked), 0);
        check("idle_state", 32'(dbg_state), 32'(IDLE));

        nominal(2);
        settle();
        check("f2_locked", 32'(locked), 0);
        check("f2_state", 32'(dbg_state), 32'(CHECK1));
        check("f2_frame_cnt", 32'(frame_cnt), 1);
        check("f2_frame_sum", 32'(frame_sum), 960);
        nominal(1);
        settle();
        check("f3_locked", 32'(locked), 1);
        check("f3_frame_cnt", 32'(frame_cnt), 2);
        check("f3_errs", {29'd0, h_err, v_err, blank_err}, 0);

        send_frame(VT, -1, VP, -1, 1);
        send_frame(VT, 7, VP, -1, 0);
        settle();
        check("long_h_err", 32'(h_err), 1);
        check("long_locked", 32'(locked), 0);
        check("long_vb_err", {30'd0, v_err, blank_err}, 0);
        nominal(2);
        settle();
        check("relock_pending", 32'(locked), 0);
        nominal(1);
        settle();
        check("relock", 32'(locked), 1);
        check("h_err_sticky", 32'(h_err), 1);
        pulse_clr();
        check("h_err_cleared", 32'(h_err), 0);

        send_frame(VT, -1, VP + 1, -1, 0);
        send_frame(VT, -1, VP + 1, -1, 0);
        settle();
        check("vpulse_v_err", 32'(v_err), 1);
        check("vpulse_state", 32'(dbg_state), 32'(SYNC));
        pulse_clr();

        send_frame(VT, -1, VP, 7, 0);
        settle();
        check("early_blank_err", 32'(blank_err), 1);
        check("early_h_err", 32'(h_err), 0);
        pulse_clr();

        send_frame(8, -1, VP, -1, 0);
        @(posedge clk); #1 nrst = 1'b0;
        @(negedge clk); #1;
        check("rst_locked", 32'(locked), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_pix_valid", 32'(pix_valid), 0);
        @(posedge clk); #1 nrst = 1'b1;
        nominal(2);
        settle();
        check("rst_relock_pending", 32'(locked), 0);
        nominal(1);
        settle();
        check("rst_relock", 32'(locked), 1);
        check("rst_frame_sum", 32'(frame_sum), 960);

        repeat (5000) drive(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        settle();
        check("sat_h_err", 32'(h_err), 1);
        check("sat_v_err", 32'(v_err), 0);
        check("sat_blank_err", 32'(blank_err), 0);
        check("sat_locked", 32'(locked), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
